dcache_wt: RTL
==============

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits directly downstream of the memory pipeline stage. Takes that stage's address, write-data and write-enable plus a read request, and returns read data and a valid/ready flag; the stage derives its stall from that flag.
- On a miss or a write it runs a word-by-word req/ack handshake to main memory.

Parameters:
- INDEX_BITS, 6, log2 of number of lines (64 lines).
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥ 2.
- ADDR_W, 32, byte-address width. Tag width = ADDR_W − 2 − log2(LINE_WORDS) − INDEX_BITS.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- rd_i  in  1  load request from memory stage.
- wr_i  in  1  store request from memory stage (the stage's wr_to_cache output).
- addr_i  in  32  byte address (the stage's addr_to_cache output); bits [1:0] ignored.
- data_i  in  32  store data (the stage's data_to_cache output).
- inv_i  in  1  invalidate all lines.
- valid_o  out  1  request complete / cache ready; feeds the stage's data_cache_valid_i.
- data_o  out  32  load data; feeds the stage's data_from_cache_i.
- mem_req_o  out  1  main-memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  word-aligned main-memory address.
- mem_wdata_o  out  32  main-memory write data.
- mem_ack_i  in  1  memory handshake completes this cycle.
- mem_rdata_i  in  32  memory read data, valid with mem_ack_i.

Behaviour:
- Reset (async, rst_n_i low):
  - state = IDLE; all valid bits = 0; refill counter = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, data_o = 0.
  - valid_o = 1 (no request in flight).
- Address split: offset = addr_i[1+log2(LINE_WORDS):2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Hit condition: valid[index] && tag_array[index] == tag.
- IDLE:
  - No request: valid_o = 1.
  - rd_i hit: valid_o = 1 combinationally in the same cycle; data_o = data_array[index][offset] (combinational). Zero-cycle latency.
  - rd_i miss: valid_o = 0; latch addr; → REFILL.
  - wr_i (hit or miss): valid_o = 0; latch addr, data and hit flag; → WRITE.
  - wr_i and rd_i together: write wins.
- REFILL:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {tag, index, cnt, 2'b00}; cnt counts 0..LINE_WORDS−1.
  - Each mem_ack_i: write mem_rdata_i into data_array[index][cnt], then cnt++.
  - mem_req_o stays high across consecutive words; the address changes the cycle after each ack.
  - Ack on the last word: set tag and valid bit, cnt = 0, → DONE.
- WRITE:
  - mem_req_o = 1, mem_we_o = 1, mem_addr_o = latched word address, mem_wdata_o = latched data.
  - On mem_ack_i: if the latched hit flag is set, update data_array word; a miss does not allocate. → DONE.
- DONE: exactly one cycle.
  - valid_o = 1, mem_req_o = 0.
  - data_o = the requested word (the word just refilled, or the array word). After a write, data_o is don't-care.
  - → IDLE.
- Outside DONE and a hitting IDLE, valid_o = 0.
- Request signals are held stable by the stage while valid_o = 0. Changes to requests outside IDLE are ignored.
- inv_i:
  - Clears all valid bits at the clock edge.
  - If asserted during REFILL, the refill completes but the line is NOT marked valid.
  - If asserted in IDLE together with a read, the read is treated as a miss.
- mem_ack_i without mem_req_o is ignored.
- Reset mid-REFILL/WRITE: aborts immediately and mem_req_o drops asynchronously. No partial line is ever valid.

Optional Feature:
- DCACHE_STATS_EN: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments once per IDLE read hit (IDLE → IDLE with rd_i). miss_cnt_o increments on each IDLE → REFILL transition.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
  - Writes count in neither.
- Without the macro, neither port nor counter logic exists.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, REFILL, WRITE, DONE};
  - localparams OFFSET_BITS and TAG_BITS;
  - a typedef for the decoded-address struct (tag/index/offset).
- Sub-module dcache_array: tag, valid and data storage.
  - Combinational read; synchronous write port; flash-clear of valid bits.
  - Instantiated once.

Test Plan:
- Cold read 0x0000_0104, memory returns 0xA0,0xA1,0xA2,0xA3 for words 0x100..0x10C, each with a 1-cycle ack delay → 4 read handshakes, DONE cycle with data_o = 0xA1 and valid_o = 1; next read 0x0000_010C hits, data_o = 0xA3 and valid_o = 1 in the same cycle, no mem_req_o.
- Write hit 0x104 with 0xDEAD_BEEF → mem_we_o = 1, mem_addr_o = 0x104 until ack; one DONE cycle; subsequent read 0x104 hits and returns 0xDEAD_BEEF.
- Write miss 0x2000 with 0x1234 → memory write only; read 0x2000 afterwards misses (no allocate).
- Conflict: read 0x0104 then read 0x1104 (same index, different tag) → second read refills and evicts; re-reading 0x0104 misses again.
- inv_i pulse mid-REFILL → refill finishes and returns data, but the same address re-read misses. Assert rst_n_i low mid-WRITE → mem_req_o = 0 immediately, valid_o = 1, all lines invalid.
- With DCACHE_STATS_EN: 1 miss + 3 hits → miss_cnt_o = 1, hit_cnt_o = 3. Force hit_cnt_o to 0xFFFFFFFF, then one more hit → stays 0xFFFFFFFF.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, FSM states and decoded-address type shared by the data cache.
package dcache_pkg;
    localparam int INDEX_BITS  = 6;
    localparam int LINE_WORDS  = 4;
    localparam int ADDR_W      = 32;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS);
    localparam int TAG_BITS    = ADDR_W - 2 - OFFSET_BITS - INDEX_BITS;
    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_e;
    typedef struct packed {
        logic [TAG_BITS-1:0]    tag;
        logic [INDEX_BITS-1:0]  index;
        logic [OFFSET_BITS-1:0] offset;
    } daddr_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/data storage with combinational read, synchronous write
// and single-cycle flash invalidate of all valid bits.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   inv_i,
    input  logic [TAG_BITS-1:0]    rd_tag_i,
    input  logic [INDEX_BITS-1:0]  rd_index_i,
    input  logic [OFFSET_BITS-1:0] rd_offset_i,
    output logic                   hit_o,
    output logic [31:0]            rd_data_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_BITS-1:0]  wr_index_i,
    input  logic [OFFSET_BITS-1:0] wr_offset_i,
    input  logic [31:0]            wr_data_i,
    input  logic                   fill_i,
    input  logic                   fill_valid_i,
    input  logic [TAG_BITS-1:0]    fill_tag_i
);
    logic [31:0]         data_q [LINES*LINE_WORDS];
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [LINES-1:0]    valid_q;

    assign hit_o     = valid_q[rd_index_i] && tag_q[rd_index_i] == rd_tag_i;
    assign rd_data_o = data_q[{rd_index_i, rd_offset_i}];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
        if (fill_i) tag_q[wr_index_i] <= fill_tag_i;
    end

    // Invalidate beats a concurrent fill so a line refilled across inv_i stays invalid.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) valid_q <= '0;
        else if (inv_i) valid_q <= '0;
        else if (fill_i && fill_valid_i) valid_q[wr_index_i] <= 1'b1;
    end
endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate L1 data cache.
// Define DCACHE_STATS_EN to add saturating hit_cnt_o/miss_cnt_o counters.
module dcache_wt
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    input  logic              inv_i,
    output logic              valid_o,
    output logic [31:0]       data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);
    state_e                 state_q;
    daddr_t                 req_q, cur, rd_sel;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic                   hit_q, inv_seen_q, mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [31:0]            mem_wdata_q, arr_rdata;
    logic                   arr_hit, hit, rd_hit, rd_miss, ack, last, unused_ok;

    assign cur       = daddr_t'(addr_i[ADDR_W-1:2]);
    assign unused_ok = ^addr_i[1:0];
    assign rd_sel    = (state_q == IDLE) ? cur : req_q;
    assign hit       = arr_hit && !inv_i;
    assign rd_hit    = state_q == IDLE && rd_i && !wr_i && hit;
    assign rd_miss   = state_q == IDLE && rd_i && !wr_i && !hit;
    assign ack       = mem_ack_i && mem_req_q;
    assign last      = cnt_q == OFFSET_BITS'(LINE_WORDS - 1);
    assign cnt_d     = cnt_q + 1'b1;

    assign valid_o     = state_q == DONE || (state_q == IDLE && !rd_i && !wr_i) || rd_hit;
    assign data_o      = (valid_o && (rd_i || state_q == DONE)) ? arr_rdata : '0;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    dcache_array u_array (
        .clk_i,
        .rst_n_i,
        .inv_i,
        .rd_tag_i     (rd_sel.tag),
        .rd_index_i   (rd_sel.index),
        .rd_offset_i  (rd_sel.offset),
        .hit_o        (arr_hit),
        .rd_data_o    (arr_rdata),
        .wr_en_i      (ack && (state_q == REFILL || hit_q)),
        .wr_index_i   (req_q.index),
        .wr_offset_i  (state_q == REFILL ? cnt_q : req_q.offset),
        .wr_data_i    (state_q == REFILL ? mem_rdata_i : mem_wdata_q),
        .fill_i       (ack && state_q == REFILL && last),
        .fill_valid_i (!inv_seen_q),
        .fill_tag_i   (req_q.tag)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE; req_q <= '0; cnt_q <= '0; hit_q <= 1'b0; inv_seen_q <= 1'b0;
            mem_req_q <= 1'b0; mem_we_q <= 1'b0; mem_addr_q <= '0; mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (wr_i) begin
                    state_q <= WRITE; req_q <= cur; hit_q <= hit;
                    mem_req_q <= 1'b1; mem_we_q <= 1'b1;
                    mem_addr_q <= {addr_i[ADDR_W-1:2], 2'b00}; mem_wdata_q <= data_i;
                end else if (rd_miss) begin
                    state_q <= REFILL; req_q <= cur; cnt_q <= '0; inv_seen_q <= 1'b0;
                    mem_req_q <= 1'b1; mem_we_q <= 1'b0;
                    mem_addr_q <= {cur.tag, cur.index, {OFFSET_BITS{1'b0}}, 2'b00};
                end
                REFILL: begin
                    if (inv_i) inv_seen_q <= 1'b1;
                    if (ack) begin
                        cnt_q <= cnt_d;
                        mem_addr_q <= {req_q.tag, req_q.index, cnt_d, 2'b00};
                        if (last) begin state_q <= DONE; mem_req_q <= 1'b0; end
                    end
                end
                WRITE: if (ack) begin
                    state_q <= DONE; mem_req_q <= 1'b0; mem_we_q <= 1'b0;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_cnt_q <= '0; miss_cnt_q <= '0;
        end else begin
            if (rd_hit && ~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (rd_miss && ~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule
